data_mem_mw: RTL and testbench

Data memory plus M->W pipeline register for the 5-stage MIPS core. It takes the M-stage address, store data and load/store type, and performs byte/halfword/word stores with lane alignment and misalignment checks. It registers the raw read word, the low address bits and the load-extension code into W. Its outputs drive the W-stage load extender directly: ReadData_W, ALUOut_W[1:0] and ExtDM_W.

---
 rtl/data_mem_mw_if.sv | 34 +++
 rtl/data_mem_mw.sv | 130 +++++++++++++
 tb/tb_data_mem_mw.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_mw_if.sv
// data_mem_mw_if: M-stage memory request and W-stage result bundle for the
// data memory / M->W pipeline register.
//   master: drives the M-stage request (En_W, MemWrite_M, StoreType_M,
//           LoadType_M, MemRead_M, ALUOut_M, WriteData_M) and receives the
//           alignment flags and the W-stage results.
//   slave : the memory block; receives the request, drives AdES_M, AdEL_M,
//           ReadData_W, ALUOut_W, ExtDM_W, AdEL_W.
interface data_mem_mw_if;
   logic        En_W;
   logic        MemWrite_M;
   logic [1:0]  StoreType_M;
   logic [2:0]  LoadType_M;
   logic        MemRead_M;
   logic [31:0] ALUOut_M;
   logic [31:0] WriteData_M;
   logic        AdES_M;
   logic        AdEL_M;
   logic [31:0] ReadData_W;
   logic [1:0]  ALUOut_W;
   logic [2:0]  ExtDM_W;
   logic        AdEL_W;

   modport master (
      output En_W, MemWrite_M, StoreType_M, LoadType_M, MemRead_M,
             ALUOut_M, WriteData_M,
      input  AdES_M, AdEL_M, ReadData_W, ALUOut_W, ExtDM_W, AdEL_W
   );

   modport slave (
      input  En_W, MemWrite_M, StoreType_M, LoadType_M, MemRead_M,
             ALUOut_M, WriteData_M,
      output AdES_M, AdEL_M, ReadData_W, ALUOut_W, ExtDM_W, AdEL_W
   );
endinterface

// File: rtl/data_mem_mw.sv
// data_mem_mw: data memory plus M->W pipeline register of the 5-stage MIPS
// core. Performs byte/halfword/word stores with lane alignment, flags
// misaligned accesses, and registers the raw read word, the low address bits
// and the load-extension code for the W-stage load extender.
// Ports:
//   clk   - pipeline clock, rising edge
//   reset - asynchronous active-high reset; clears W registers and memory
//   bus   - data_mem_mw_if.slave: M-stage request in, AdES_M/AdEL_M
//           (combinational) and ReadData_W/ALUOut_W/ExtDM_W/AdEL_W
//           (registered) out
module data_mem_mw #(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic          clk,
   input  logic          reset,
   data_mem_mw_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_SW  = 2'b00,
      ST_SB  = 2'b01,
      ST_SH  = 2'b10,
      ST_RSV = 2'b11
   } store_e;

   typedef enum logic [2:0] {
      LD_LW  = 3'b000,
      LD_LBU = 3'b001,
      LD_LB  = 3'b010,
      LD_LHU = 3'b011,
      LD_LH  = 3'b100
   } load_e;

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [31:0]           mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0] idx;
   logic [1:0]            a_lo;
   logic                  is_sw, is_sh, is_sb;
   logic                  is_lw, is_lhx;
   logic                  ades, adel;
   logic [3:0]            be;
   logic [31:0]           lane;
   logic [31:0]           mask;
   logic [31:0]           cur_word;
   logic [31:0]           merged;
   logic                  we;

   logic [31:0]           rdata_q, rdata_d;
   logic [1:0]            alu_q, alu_d;
   logic [2:0]            ext_q, ext_d;
   logic                  adel_q, adel_d;

   // Address bits above the word index are ignored so addresses alias.
   logic                  unused_addr;
   assign unused_addr = ^bus.ALUOut_M[31:ADDR_WIDTH+2];

   assign idx      = bus.ALUOut_M[ADDR_WIDTH+1:2];
   assign a_lo     = bus.ALUOut_M[1:0];
   assign cur_word = mem_q[idx];

   always_comb begin
      is_sw  = (bus.StoreType_M == ST_SW) || (bus.StoreType_M == ST_RSV);
      is_sh  = (bus.StoreType_M == ST_SH);
      is_sb  = (bus.StoreType_M == ST_SB);
      is_lw  = (bus.LoadType_M == LD_LW);
      is_lhx = (bus.LoadType_M == LD_LH) || (bus.LoadType_M == LD_LHU);

      ades = bus.MemWrite_M & ((is_sw & (a_lo != 2'b00)) | (is_sh & a_lo[0]));
      adel = bus.MemRead_M  & ((is_lw & (a_lo != 2'b00)) | (is_lhx & a_lo[0]));

      be   = 4'b1111;
      lane = bus.WriteData_M;
      if (is_sh) begin
         be   = a_lo[1] ? 4'b1100 : 4'b0011;
         lane = {2{bus.WriteData_M[15:0]}};
      end else if (is_sb) begin
         be   = 4'b0001 << a_lo;
         lane = {4{bus.WriteData_M[7:0]}};
      end

      // Expand byte enables to a bit mask so untouched lanes keep their value.
      mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      merged = (cur_word & ~mask) | (lane & mask);
      we     = bus.MemWrite_M & bus.En_W & ~ades;
   end

   always_comb begin
      rdata_d = rdata_q;
      alu_d   = alu_q;
      ext_d   = ext_q;
      adel_d  = adel_q;
      if (bus.En_W) begin
         rdata_d = cur_word;
         alu_d   = a_lo;
         ext_d   = bus.LoadType_M;
         adel_d  = adel;
      end
   end

   // Read-first: the W register samples the word before the same-edge write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
         alu_q   <= '0;
         ext_q   <= '0;
         adel_q  <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         rdata_q <= rdata_d;
         alu_q   <= alu_d;
         ext_q   <= ext_d;
         adel_q  <= adel_d;
         if (we) begin
            mem_q[idx] <= merged;
         end
      end
   end

   assign bus.AdES_M     = ades;
   assign bus.AdEL_M     = adel;
   assign bus.ReadData_W = rdata_q;
   assign bus.ALUOut_W   = alu_q;
   assign bus.ExtDM_W    = ext_q;
   assign bus.AdEL_W     = adel_q;

endmodule

// File: tb/tb_data_mem_mw.sv
module tb_data_mem_mw;

   localparam int unsigned AW = 10;

   typedef struct {
      logic [31:0] rd;
      logic [1:0]  alu;
      logic [2:0]  ext;
      logic        adel;
   } wexp_t;

   logic clk;
   logic reset;
   data_mem_mw_if bus ();

   data_mem_mw #(.ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [31:0] ref_mem [2**AW];
   wexp_t       held;
   wexp_t       sb_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic ades_f(input logic w, input logic [1:0] st, input logic [31:0] a);
      if (!w) return 1'b0;
      if (st == 2'd0 || st == 2'd3) return a[1:0] != 2'b00;
      if (st == 2'd2) return a[0];
      return 1'b0;
   endfunction

   function automatic logic adel_f(input logic r, input logic [2:0] lt, input logic [31:0] a);
      if (!r) return 1'b0;
      if (lt == 3'd0) return a[1:0] != 2'b00;
      if (lt == 3'd3 || lt == 3'd4) return a[0];
      return 1'b0;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 2**AW; i++) ref_mem[i] = 32'h0;
      held.rd = '0; held.alu = '0; held.ext = '0; held.adel = 1'b0;
   endtask

   // Called at posedge+1; checks M-stage flags at the negedge, the W outputs
   // after the next rising edge.
   task automatic step(input logic en, input logic w, input logic r, input logic [1:0] st,
                       input logic [2:0] lt, input logic [31:0] a, input logic [31:0] wd);
      wexp_t e, got;
      logic [31:0] word;
      logic [AW-1:0] ix;
      bus.En_W = en; bus.MemWrite_M = w; bus.MemRead_M = r;
      bus.StoreType_M = st; bus.LoadType_M = lt;
      bus.ALUOut_M = a; bus.WriteData_M = wd;
      #4;
      chk("AdES_M", {31'b0, bus.AdES_M}, {31'b0, ades_f(w, st, a)});
      chk("AdEL_M", {31'b0, bus.AdEL_M}, {31'b0, adel_f(r, lt, a)});
      ix = a[AW+1:2];
      if (en) begin
         e.rd = ref_mem[ix]; e.alu = a[1:0]; e.ext = lt; e.adel = adel_f(r, lt, a);
         held = e;
         if (w && !ades_f(w, st, a)) begin
            word = ref_mem[ix];
            case (st)
               2'd1: word[a[1:0]*8 +: 8] = wd[7:0];
               2'd2: if (a[1]) word[31:16] = wd[15:0]; else word[15:0] = wd[15:0];
               default: word = wd;
            endcase
            ref_mem[ix] = word;
         end
      end else begin
         e = held;
      end
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got.rd = bus.ReadData_W;
      e = sb_q.pop_front();
      chk("ReadData_W", got.rd, e.rd);
      chk("ALUOut_W", {30'b0, bus.ALUOut_W}, {30'b0, e.alu});
      chk("ExtDM_W", {29'b0, bus.ExtDM_W}, {29'b0, e.ext});
      chk("AdEL_W", {31'b0, bus.AdEL_W}, {31'b0, e.adel});
   endtask

   task automatic check_w_zero(input string tag);
      chk({tag, "_ReadData_W"}, bus.ReadData_W, 32'h0);
      chk({tag, "_ALUOut_W"}, {30'b0, bus.ALUOut_W}, 32'h0);
      chk({tag, "_ExtDM_W"}, {29'b0, bus.ExtDM_W}, 32'h0);
      chk({tag, "_AdEL_W"}, {31'b0, bus.AdEL_W}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] ra;
      logic [1:0]  rst_t;
      logic [2:0]  rlt;
      logic        rw, rr, ren;
      reset = 1'b1;
      bus.En_W = 1'b0; bus.MemWrite_M = 1'b0; bus.MemRead_M = 1'b0;
      bus.StoreType_M = '0; bus.LoadType_M = '0;
      bus.ALUOut_M = '0; bus.WriteData_M = '0;
      clear_model();
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      check_w_zero("reset");

      // lw after reset
      step(1, 0, 1, 2'd0, 3'd0, 32'h0000_0010, 32'h0);
      // sh over an empty word, then lh
      step(1, 1, 0, 2'd2, 3'd0, 32'h0000_0022, 32'h0000_BEEF);
      step(1, 0, 1, 2'd0, 3'd4, 32'h0000_0022, 32'h0);
      chk("sh_lh_word", bus.ReadData_W, 32'hBEEF_0000);
      // sw, sb, lw
      step(1, 1, 0, 2'd0, 3'd0, 32'h0000_0020, 32'h1234_5678);
      step(1, 1, 0, 2'd1, 3'd0, 32'h0000_0021, 32'h0000_00AB);
      step(1, 0, 1, 2'd0, 3'd0, 32'h0000_0020, 32'h0);
      chk("sw_sb_lw_word", bus.ReadData_W, 32'h1234_AB78);
      // misaligned sw must not write; misaligned lhu flags AdEL
      step(1, 1, 0, 2'd0, 3'd0, 32'h0000_0023, 32'hDEAD_BEEF);
      step(1, 0, 1, 2'd0, 3'd0, 32'h0000_0020, 32'h0);
      chk("ades_no_write", bus.ReadData_W, 32'h1234_AB78);
      step(1, 0, 1, 2'd0, 3'd3, 32'h0000_0021, 32'h0);
      // reserved store type behaves as sw
      step(1, 1, 0, 2'd3, 3'd0, 32'h0000_0030, 32'hA5A5_5A5A);
      step(1, 0, 1, 2'd0, 3'd7, 32'h0000_0030, 32'h0);
      // stall during sw 0xFFFFFFFF @0x40
      for (int i = 0; i < 3; i++) step(0, 1, 0, 2'd0, 3'd0, 32'h0000_0040, 32'hFFFF_FFFF);
      step(1, 1, 0, 2'd0, 3'd0, 32'h0000_0040, 32'hFFFF_FFFF);
      chk("stall_no_write", bus.ReadData_W, 32'h0);
      step(1, 0, 1, 2'd0, 3'd0, 32'h0000_0040, 32'h0);
      chk("post_stall_store", bus.ReadData_W, 32'hFFFF_FFFF);

      // asynchronous reset mid-cycle with a store presented
      bus.MemWrite_M = 1'b1; bus.En_W = 1'b1; bus.ALUOut_M = 32'h40; bus.WriteData_M = 32'hDEAD_0001;
      #2;
      reset = 1'b1;
      #1;
      check_w_zero("async_reset");
      clear_model();
      @(posedge clk); #1;
      reset = 1'b0;
      step(1, 0, 1, 2'd0, 3'd0, 32'h0000_0040, 32'h0);
      step(1, 0, 1, 2'd0, 3'd0, 32'h0000_0040 + 4 * (2**AW), 32'h0);
      // aliasing: store through the high alias, read through the base
      step(1, 1, 0, 2'd0, 3'd0, 32'h0000_0040 + 4 * (2**AW), 32'hCAFE_F00D);
      step(1, 0, 1, 2'd0, 3'd0, 32'h0000_0040, 32'h0);
      chk("alias_word", bus.ReadData_W, 32'hCAFE_F00D);

      // random mix over a small aliased region
      for (int i = 0; i < 60; i++) begin
         ra    = $urandom & 32'hFFFF_F03F;
         rst_t = 2'($urandom_range(0, 3));
         rlt   = 3'($urandom_range(0, 7));
         rw    = ($urandom_range(0, 1) == 1);
         rr    = !rw;
         ren   = ($urandom_range(0, 4) != 0);
         step(ren, rw, rr, rst_t, rlt, ra, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
